// File: rtl/sne_evt_filter_pkg.sv
// Shared types and constants for the event range filter.
package sne_evt_filter_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W_DEF = 16;
  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic logic in_range(
    input logic        en,
    input logic [31:0] f,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return !en || (lo <= f && f <= hi);
  endfunction
endpackage

// File: rtl/sne_evt_stream_pkg.sv
// Event word type shared by every stage on the SNE event stream.
package sne_evt_stream_pkg;
  localparam int EVT_W = 32;
  typedef logic [EVT_W-1:0] evt_t;
endpackage

// File: rtl/sne_event_stream_if.sv
// Valid/ready event stream; src drives events, dst consumes them.
interface SNE_EVENT_STREAM;
  import sne_evt_stream_pkg::*;
  logic valid;
  logic ready;
  evt_t evt;
  modport src(output valid, output evt, input ready);
  modport dst(input valid, input evt, output ready);
endinterface

// File: rtl/evt_filter_buf.sv
// Two-entry registered FIFO slice; ready depends only on occupancy.
module evt_filter_buf
  import sne_evt_filter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  input  logic         pop_ready,
  output logic [1:0]   occ
);
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic push;
  logic pop;

  assign push_ready = (occ != 2'(BUF_DEPTH));
  assign pop_valid  = (occ != 2'd0);
  assign pop_data   = head;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // head only moves on pop or on a push into an empty slice
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (occ == 2'd0) head <= push_data;
          else tail <= push_data;
          occ <= occ + 2'd1;
        end
        pop && !push: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        push && pop: head <= push_data;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/evt_filter.sv
// Forwards events whose destination field lies in [lo_i, hi_i];
// drops the rest and keeps saturating pass/drop counters.
module evt_filter
  import sne_evt_filter_pkg::*;
  import sne_evt_stream_pkg::*;
#(
  parameter int FIELD_LSB = 0,
  parameter int FIELD_W   = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  SNE_EVENT_STREAM.dst       evt_stream_dst,
  SNE_EVENT_STREAM.src       evt_stream_src,
  input  logic               en_i,
  input  logic [FIELD_W-1:0] lo_i,
  input  logic [FIELD_W-1:0] hi_i,
  input  logic               clr_i,
  output logic [CNT_W-1:0]   pass_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);
  logic [FIELD_W-1:0] field;
  logic match;
  logic accept;
  logic [1:0] buf_occ;
  logic unused_rdy;

  assign field  = evt_stream_dst.evt[FIELD_LSB +: FIELD_W];
  assign match  = in_range(en_i, 32'(field), 32'(lo_i), 32'(hi_i));
  assign evt_stream_dst.ready = (buf_occ != 2'(BUF_DEPTH));
  assign accept = evt_stream_dst.valid && evt_stream_dst.ready;

  evt_filter_buf #(
    .W(EVT_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_valid(evt_stream_dst.valid && match),
    .push_data (evt_stream_dst.evt),
    .push_ready(unused_rdy),
    .pop_valid (evt_stream_src.valid),
    .pop_data  (evt_stream_src.evt),
    .pop_ready (evt_stream_src.ready),
    .occ       (buf_occ)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (accept && match && pass_cnt_o != '1)
        pass_cnt_o <= pass_cnt_o + CNT_W'(1);
      if (accept && !match && drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_evt_filter.sv
// Randomized bench for evt_filter with a queue-based reference model.
module tb_evt_filter;
  import sne_evt_stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, clr, in_valid, out_ready;
  logic [7:0] lo, hi;
  evt_t in_evt;
  logic [15:0] pass16, drop16;
  logic [3:0] pass4, drop4;

  SNE_EVENT_STREAM s_in();
  SNE_EVENT_STREAM s_out();
  SNE_EVENT_STREAM s_in4();
  SNE_EVENT_STREAM s_out4();

  assign s_in.valid   = in_valid;
  assign s_in.evt     = in_evt;
  assign s_out.ready  = out_ready;
  assign s_in4.valid  = in_valid;
  assign s_in4.evt    = in_evt;
  assign s_out4.ready = out_ready;

  evt_filter #(.FIELD_LSB(0), .FIELD_W(8), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .evt_stream_dst(s_in), .evt_stream_src(s_out),
    .en_i(en), .lo_i(lo), .hi_i(hi), .clr_i(clr),
    .pass_cnt_o(pass16), .drop_cnt_o(drop16)
  );

  evt_filter #(.FIELD_LSB(0), .FIELD_W(8), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .evt_stream_dst(s_in4), .evt_stream_src(s_out4),
    .en_i(en), .lo_i(lo), .hi_i(hi), .clr_i(clr),
    .pass_cnt_o(pass4), .drop_cnt_o(drop4)
  );

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  evt_t exp_q[$];
  evt_t got_q[$];
  int acc_cyc_q[$];
  int pop_cyc_q[$];
  int pass_m = 0, drop_m = 0;
  int unstable = 0, ready_low = 0, valid_seen = 0;
  logic hold_v = 1'b0;
  evt_t hold_e;
  logic acc_now = 1'b0;

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_model();
    exp_q.delete(); got_q.delete();
    acc_cyc_q.delete(); pop_cyc_q.delete();
    unstable = 0; ready_low = 0; valid_seen = 0;
  endtask

  // advance one clock, recording handshakes into the model
  task automatic cycle();
    int f;
    @(negedge clk);
    acc_now = 1'b0;
    if (in_valid && s_in.ready) begin
      acc_now = 1'b1;
      f = int'(in_evt[7:0]);
      if (!en || (f >= int'(lo) && f <= int'(hi))) begin
        exp_q.push_back(in_evt);
        acc_cyc_q.push_back(cyc);
        pass_m++;
      end else drop_m++;
    end
    if (clr) begin pass_m = 0; drop_m = 0; end
    if (!s_in.ready) ready_low++;
    if (s_out.valid) begin
      valid_seen++;
      if (hold_v && s_out.evt !== hold_e) unstable++;
      hold_v = !out_ready;
      hold_e = s_out.evt;
      if (out_ready) begin
        got_q.push_back(s_out.evt);
        pop_cyc_q.push_back(cyc);
      end
    end else hold_v = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(evt_t e);
    in_valid = 1'b1;
    in_evt = e;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (acc_now) break;
    end
    in_valid = 1'b0;
    vectors++;
    if (!acc_now) begin
      errors++;
      $display("FAIL send_timeout: evt %0h never accepted", e);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) cycle();
    cycle();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (s_out.valid !== 1'b0 || s_in.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid %b ready %b want 0 1", s_out.valid, s_in.ready);
    end
    vectors++;
    if (pass16 !== 16'd0 || drop16 !== 16'd0 || s_out.evt !== '0) begin
      errors++;
      $display("FAIL reset_state: pass %0d drop %0d evt %0h want 0 0 0", pass16, drop16, s_out.evt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthru();
    evt_t sent[10];
    clear_model();
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sent[i] = $urandom();
      send(sent[i]);
    end
    drain();
    vectors++;
    if (got_q.size() != 10) begin
      errors++;
      $display("FAIL pt_count: got %0d want 10", got_q.size());
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== sent[i] || pop_cyc_q[i] != acc_cyc_q[i] + 1) begin
        errors++;
        $display("FAIL pt_evt%0d: got %0h @%0d want %0h @%0d", i, got_q[i], pop_cyc_q[i], sent[i], acc_cyc_q[i] + 1);
      end
    end
    vectors++;
    if (pass16 !== 16'd10 || drop16 !== 16'd0) begin
      errors++;
      $display("FAIL pt_cnt: pass %0d drop %0d want 10 0", pass16, drop16);
    end
  endtask

  task automatic test_range_bounds();
    logic [7:0] fl[4];
    evt_t g;
    fl[0] = 8'h0f; fl[1] = 8'h10; fl[2] = 8'h20; fl[3] = 8'h21;
    do_clr();
    clear_model();
    en = 1'b1; lo = 8'h10; hi = 8'h20;
    for (int i = 0; i < 4; i++)
      send(($urandom() & 32'hffffff00) | 32'(fl[i]));
    drain();
    vectors++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL rb_count: got %0d want 2", got_q.size());
    end else begin
      g = got_q[0];
      vectors++;
      if (g[7:0] !== 8'h10 || g !== exp_q[0]) begin
        errors++;
        $display("FAIL rb_lo: got %0h want field 10", g);
      end
      g = got_q[1];
      vectors++;
      if (g[7:0] !== 8'h20 || g !== exp_q[1]) begin
        errors++;
        $display("FAIL rb_hi: got %0h want field 20", g);
      end
    end
    vectors++;
    if (pass16 !== 16'd2 || drop16 !== 16'd2) begin
      errors++;
      $display("FAIL rb_cnt: pass %0d drop %0d want 2 2", pass16, drop16);
    end
  endtask

  task automatic test_backpressure();
    evt_t e[3];
    int held;
    do_clr();
    clear_model();
    en = 1'b1; lo = 8'h00; hi = 8'hff;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) e[i] = $urandom();
    send(e[0]);
    send(e[1]);
    in_valid = 1'b1;
    in_evt = e[2];
    held = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (acc_now) held++;
    end
    vectors++;
    if (held != 0 || s_in.ready !== 1'b0 || ready_low == 0) begin
      errors++;
      $display("FAIL bp_full: accepts %0d ready %b want 0 0", held, s_in.ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !acc_now; k++) cycle();
    in_valid = 1'b0;
    drain();
    vectors++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d want 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== e[i]) begin
        errors++;
        $display("FAIL bp_evt%0d: got %0h want %0h", i, got_q[i], e[i]);
      end
    end
    vectors++;
    if (unstable != 0 || pass16 !== 16'd3) begin
      errors++;
      $display("FAIL bp_stable: unstable %0d pass %0d want 0 3", unstable, pass16);
    end
  endtask

  task automatic test_empty_range();
    do_clr();
    clear_model();
    en = 1'b1; lo = 8'h30; hi = 8'h20;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send($urandom());
    repeat (3) cycle();
    vectors++;
    if (valid_seen != 0 || ready_low != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL er_out: valid %0d ready_low %0d got %0d want 0 0 0", valid_seen, ready_low, got_q.size());
    end
    vectors++;
    if (drop16 !== 16'd5 || pass16 !== 16'd0) begin
      errors++;
      $display("FAIL er_cnt: drop %0d pass %0d want 5 0", drop16, pass16);
    end
  endtask

  task automatic test_saturate_clr();
    do_clr();
    clear_model();
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send($urandom());
    drain();
    vectors++;
    if (pass4 !== 4'd15 || 32'(pass16) != sat(pass_m, 16) || pass_m != 20) begin
      errors++;
      $display("FAIL sat_cnt: pass4 %0d pass16 %0d want 15 20", pass4, pass16);
    end
    clr = 1'b1;
    in_valid = 1'b1;
    in_evt = $urandom();
    cycle();
    clr = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (!acc_now || pass4 !== 4'd0 || pass16 !== 16'd0) begin
      errors++;
      $display("FAIL sat_clr: acc %b pass4 %0d pass16 %0d want 1 0 0", acc_now, pass4, pass16);
    end
    drain();
    vectors++;
    if (got_q.size() != 21) begin
      errors++;
      $display("FAIL sat_out: got %0d want 21", got_q.size());
    end
  endtask

  task automatic test_random();
    int nbad;
    do_clr();
    clear_model();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        en = ($urandom_range(0, 3) != 0);
        lo = 8'($urandom_range(0, 255));
        hi = 8'($urandom_range(0, 255));
      end
      if (!in_valid || acc_now) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_evt = $urandom();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0;
    drain();
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    vectors++;
    if (nbad != 0 || got_q.size() != exp_q.size() || unstable != 0) begin
      errors++;
      $display("FAIL rnd_stream: bad %0d got %0d want %0d unstable %0d", nbad, got_q.size(), exp_q.size(), unstable);
    end
    vectors++;
    if (32'(pass16) != sat(pass_m, 16) || 32'(drop16) != sat(drop_m, 16)) begin
      errors++;
      $display("FAIL rnd_cnt16: pass %0d drop %0d want %0d %0d", pass16, drop16, sat(pass_m, 16), sat(drop_m, 16));
    end
    vectors++;
    if (32'(pass4) != sat(pass_m, 4) || 32'(drop4) != sat(drop_m, 4)) begin
      errors++;
      $display("FAIL rnd_cnt4: pass %0d drop %0d want %0d %0d", pass4, drop4, sat(pass_m, 4), sat(drop_m, 4));
    end
  endtask

  task automatic test_mid_reset();
    evt_t e;
    clear_model();
    en = 1'b0;
    out_ready = 1'b0;
    send($urandom());
    send($urandom());
    vectors++;
    if (s_out.valid !== 1'b1 || s_in.ready !== 1'b0) begin
      errors++;
      $display("FAIL mr_full: valid %b ready %b want 1 0", s_out.valid, s_in.ready);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (s_out.valid !== 1'b0 || pass16 !== 16'd0) begin
      errors++;
      $display("FAIL mr_async: valid %b pass %0d want 0 0", s_out.valid, pass16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pass_m = 0; drop_m = 0; hold_v = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    vectors++;
    if (s_out.valid !== 1'b0 || s_in.ready !== 1'b1 || pass16 !== 16'd0 || drop16 !== 16'd0 || s_out.evt !== '0) begin
      errors++;
      $display("FAIL mr_after: valid %b ready %b pass %0d drop %0d evt %0h", s_out.valid, s_in.ready, pass16, drop16, s_out.evt);
    end
    out_ready = 1'b1;
    e = $urandom();
    send(e);
    drain();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== e || pop_cyc_q[0] != acc_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL mr_first: got %0d events want exactly %0h", got_q.size(), e);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    in_valid = 1'b0; in_evt = '0; out_ready = 1'b0;
    lo = 8'h00; hi = 8'hff;
    test_reset();
    test_passthru();
    test_range_bounds();
    test_backpressure();
    test_empty_range();
    test_saturate_clr();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
